comm_rr_arbiter: RTL
====================

// Module: comm_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one comm channel between 4 transmitters.
//  Picks one requester, then holds the grant for a burst of up to MAX_BURST beats.
//  Muxes the winner's data onto the channel and drives the 2-bit select via enco_4to2.
//  Sits between the per-source TX buffers and the shared channel/modulator stage.
// PARAMETERS
//  DATA_W     8  width of one data beat
//  MAX_BURST  8  max beats per grant (>=1); counter width = $clog2(MAX_BURST+1)
// PORTS
//  clk        in   1         single clock, all logic on posedge
//  rst_n      in   1         synchronous, active-low reset
//  req        in   4         per-source request (level)
//  tx_valid   in   4         per-source data valid
//  tx_data    in   4*DATA_W  source i at [i*DATA_W +: DATA_W]
//  tx_ready   out  4         per-source beat accepted
//  ch_ready   in   1         channel can take a beat
//  ch_valid   out  1         beat on ch_data is valid
//  ch_data    out  DATA_W    muxed beat
//  ch_sel     out  2         binary index of current owner
//  gnt        out  4         one-hot grant, 0 when idle
//  busy       out  1         high in GRANT/XFER
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, gnt=0, ch_sel=0, ch_valid=0, tx_ready=0,
//   ch_data=0, busy=0, rr_ptr=0, beat_cnt=0. Mid-burst reset aborts; no beat completes.
//  FSM: IDLE -> GRANT -> XFER -> IDLE.
//   IDLE: if |req, register winner = first set bit of req scanning from rr_ptr
//    upward with wrap (rr_ptr, rr_ptr+1, ... mod 4); gnt<=onehot(winner); go GRANT.
//   GRANT: one setup cycle; ch_sel valid and stable; no transfer; beat_cnt<=0; go XFER.
//   XFER: ch_valid = tx_valid[sel]; ch_data = tx_data[sel]; tx_ready[sel] = ch_ready;
//    tx_ready of non-owners = 0. Beat = ch_valid & ch_ready; beat_cnt++ per beat.
//    Release when (beat this cycle and beat_cnt+1==MAX_BURST) or
//    (req[sel]==0 and no beat this cycle). Release: gnt<=0, rr_ptr<=sel+1 (wraps 3->0),
//    go IDLE.
//  Latency: req to first possible beat = 2 cycles (IDLE, GRANT); 1 idle cycle between
//   bursts (IDLE re-arbitrates).
//  ch_valid, tx_ready, ch_data are combinational from state/gnt in XFER, else 0.
//  gnt, ch_sel, busy are registered; ch_sel unchanged on IDLE (holds last owner).
//  req changes of non-owners during a burst are ignored until IDLE.
//  req[sel] dropped while a beat completes the same cycle: beat counts, release next
//   cycle if still low.
//  tx_valid low in XFER: no beat, grant held (stall) while req[sel]=1.
//  ch_sel always equals the enco_4to2 encoding of gnt whenever gnt is non-zero.
// STRUCTURE
//  Shared package comm_defs: state localparams (IDLE=2'd0, GRANT=2'd1, XFER=2'd2),
//   NUM_SRC=4.
//  Sub-module: enco_4to2 instance converts registered next-gnt one-hot -> ch_sel.
//  Rotating priority pick is a local function; data mux is an indexed part-select.
// TESTING
//  1 Reset: rst_n=0 2 cycles with req=4'hF -> gnt=0, ch_valid=0, busy=0, rr_ptr=0.
//  2 Single source: req=4'b0100, tx_valid=1, ch_ready=1, MAX_BURST=8 -> gnt=4'b0100,
//    ch_sel=2, first beat 2 cycles after req, exactly 8 beats, then gnt=0 for 1 cycle.
//  3 Fairness: req=4'hF held -> grant order 0,1,2,3,0 with 8 beats each.
//  4 Early release: src 1 drops req after 3 beats -> 3 beats, rr_ptr=2, next grant to 2.
//  5 Backpressure: ch_ready toggles 1,0,1,0 -> beat_cnt advances only when ch_ready=1,
//    tx_ready[sel] mirrors ch_ready, data held stable.
//  6 Mid-burst reset after 4 beats -> next cycle all outputs 0, re-arbitration from src 0.

Source files
------------

// File: rtl/comm_rr_arbiter_pkg.sv
// Shared definitions for the comm-channel round-robin arbiter.
package comm_defs;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/comm_rr_arbiter_enco_4to2.sv
// 4-to-2 one-hot to binary encoder; lowest set bit wins if several are set.
module enco_4to2 (
  input  logic [3:0] onehot,
  output logic [1:0] code,
  output logic       valid
);

  always_comb begin
    code = '0;
    if (onehot[0])      code = 2'd0;
    else if (onehot[1]) code = 2'd1;
    else if (onehot[2]) code = 2'd2;
    else if (onehot[3]) code = 2'd3;
  end

  assign valid = |onehot;

endmodule

// File: rtl/comm_rr_arbiter.sv
// Round-robin burst arbiter sharing one comm channel between four TX sources.
module comm_rr_arbiter
  import comm_defs::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC-1:0]         tx_valid,
  input  logic [NUM_SRC*DATA_W-1:0]  tx_data,
  output logic [NUM_SRC-1:0]         tx_ready,
  input  logic                       ch_ready,
  output logic                       ch_valid,
  output logic [DATA_W-1:0]          ch_data,
  output logic [SEL_W-1:0]           ch_sel,
  output logic [NUM_SRC-1:0]         gnt,
  output logic                       busy
);

  localparam int unsigned          CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_t             state;
  logic [SEL_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;
  logic [NUM_SRC-1:0] gnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               sel_nxt_vld;
  logic               beat;
  logic               rel;

  // First requester at or after ptr, wrapping modulo NUM_SRC.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                              input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    ch_valid = 1'b0;
    ch_data  = '0;
    tx_ready = '0;
    if (state == XFER) begin
      ch_valid = tx_valid[ch_sel];
      ch_data  = tx_data[ch_sel*DATA_W +: DATA_W];
      tx_ready = ch_ready ? gnt : '0;
    end
  end

  assign beat = ch_valid & ch_ready;
  assign rel  = (state == XFER) &&
                ((beat && (beat_cnt == LAST_CNT)) || (!req[ch_sel] && !beat));

  always_comb begin
    gnt_nxt = gnt;
    case (state)
      IDLE:    if (|req) gnt_nxt = onehot(rr_pick(req, rr_ptr));
      XFER:    if (rel) gnt_nxt = '0;
      default: ;
    endcase
  end

  // ch_sel is registered from the encoded next grant, so it only moves on a
  // new award and keeps the last owner while the grant is dropped.
  enco_4to2 u_enco (
    .onehot (gnt_nxt),
    .code   (sel_nxt),
    .valid  (sel_nxt_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      ch_sel   <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      gnt <= gnt_nxt;
      if (sel_nxt_vld) ch_sel <= sel_nxt;
      case (state)
        IDLE: begin
          if (|req) begin
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          beat_cnt <= '0;
          state    <= XFER;
        end
        XFER: begin
          if (beat) beat_cnt <= beat_cnt + CNT_W'(1);
          if (rel) begin
            busy   <= 1'b0;
            rr_ptr <= ch_sel + SEL_W'(1);
            state  <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
